uart_tx: RTL and testbench

UART transmitter that sits on the send side of the APB-UART, opposite the existing receiver path. It buffers bytes from the register interface in an internal FIFO and frames each byte as start, 8 data bits LSB-first, optional parity, and stop. It then shifts the frame out on `data_tx` at a selectable baud rate. Frame format, parity encoding and baud encoding are identical to the receiver's, so a looped-back `data_tx` is received error-free.

---
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter, 8 data bits LSB-first, optional parity, one stop bit.
// Ports: clock/reset (sync, active-high); parity_type (00/11 none, 01 odd, 10 even);
//        baud_rate (00 2400, 01 4800, 10 9600, 11 19200); data_in/send push a byte;
//        data_tx serial line; tx_active_flag, tx_done_flag frame status;
//        fifo_full/fifo_empty registered status; fifo_err pulse on rejected push.
module uart_tx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int DEPTH  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] parity_type,
    input  logic [1:0] baud_rate,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       data_tx,
    output logic       tx_active_flag,
    output logic       tx_done_flag,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic       fifo_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = $clog2(CLK_HZ / 2400 + 1);
    localparam logic [CW-1:0] DIV0 = CW'(CLK_HZ / 2400);
    localparam logic [CW-1:0] DIV1 = CW'(CLK_HZ / 4800);
    localparam logic [CW-1:0] DIV2 = CW'(CLK_HZ / 9600);
    localparam logic [CW-1:0] DIV3 = CW'(CLK_HZ / 19200);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state, next;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [NW-1:0] count, count_next;
    logic          push, pop, tick, has_par, par_bit, line_next;
    logic [7:0]    shreg;
    logic [1:0]    par_q, baud_q;
    logic [CW-1:0] cnt, div;
    logic [2:0]    bit_cnt, bit_next;

    assign push       = send && !fifo_full;
    assign count_next = count + NW'(push) - NW'(pop);

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fifo_full  <= 1'b0;
            fifo_empty <= 1'b1;
            fifo_err   <= 1'b0;
        end else begin
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count      <= count_next;
            fifo_full  <= count_next == NW'(DEPTH);
            fifo_empty <= count_next == '0;
            fifo_err   <= send && fifo_full;
        end
    end

    // Bit timing follows the baud setting latched at frame start, not the live input.
    assign div     = baud_q == 2'b00 ? DIV0 : baud_q == 2'b01 ? DIV1 : baud_q == 2'b10 ? DIV2 : DIV3;
    assign tick    = cnt == div - CW'(1);
    assign has_par = par_q[0] ^ par_q[1];
    assign par_bit = ^shreg ^ (par_q == 2'b01);

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = fifo_empty ? IDLE : START;
            START:   next = tick ? DATA : START;
            DATA:    next = (tick && bit_cnt == 3'd7) ? (has_par ? PARITY : STOP) : DATA;
            PARITY:  next = tick ? STOP : PARITY;
            STOP:    next = tick ? (fifo_empty ? IDLE : START) : STOP;
            default: next = IDLE;
        endcase
    end

    // The line level is computed for the state being entered so data_tx can be a plain register.
    always_comb begin
        pop            = !fifo_empty && (state == IDLE || (state == STOP && tick));
        tx_done_flag   = state == STOP && tick;
        tx_active_flag = state != IDLE;
        bit_next       = (state == DATA && tick) ? bit_cnt + 3'd1 : bit_cnt;
        line_next      = next == START ? 1'b0 :
                         next == DATA ? shreg[bit_next] :
                         next == PARITY ? par_bit : 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_tx <= 1'b1;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_q   <= '0;
            baud_q  <= '0;
        end else begin
            data_tx <= line_next;
            cnt     <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
            if (pop) begin
                shreg   <= mem[rd_ptr];
                par_q   <= parity_type;
                baud_q  <= baud_rate;
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_next;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx; a line monitor decodes each frame against queued expectations.
module tb_uart_tx;
    localparam int CLK = 192000;

    typedef struct {
        logic [7:0] b;
        logic [1:0] par;
        logic [1:0] baud;
    } ent_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] parity_type;
    logic [1:0] baud_rate;
    logic [7:0] data_in;
    logic       send;
    logic       data_tx, tx_active_flag, tx_done_flag, fifo_full, fifo_empty, fifo_err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   dn_cnt = 0;
    ent_t q[$];

    bit          in_frame = 1'b0;
    ent_t        cur;
    int          k, div, len, good, act, xdone;
    logic [10:0] bits;

    uart_tx #(.CLK_HZ(CLK), .DEPTH(8)) dut (
        .clock(clock),
        .reset(reset),
        .parity_type(parity_type),
        .baud_rate(baud_rate),
        .data_in(data_in),
        .send(send),
        .data_tx(data_tx),
        .tx_active_flag(tx_active_flag),
        .tx_done_flag(tx_done_flag),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_err(fifo_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) if (tx_done_flag) dn_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Frame decoder: every cycle of every bit must hold the expected level.
    always @(negedge clock) begin
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && data_tx == 1'b0) begin
                if (q.size() == 0) begin
                    chk("spurious_start", 1, 0);
                end else begin
                    cur      = q.pop_front();
                    div      = CLK / (2400 << cur.baud);
                    len      = (cur.par == 2'b01 || cur.par == 2'b10) ? 11 : 10;
                    bits     = {1'b1, (len == 11) ? (^cur.b ^ (cur.par == 2'b01)) : 1'b1, cur.b, 1'b0};
                    k        = 0;
                    good     = 0;
                    act      = 0;
                    xdone    = 0;
                    in_frame = 1'b1;
                end
            end
            if (in_frame) begin
                if (data_tx == bits[k / div]) good++;
                if (tx_active_flag) act++;
                if (k % div == div - 1) begin
                    chk("bit_level", good, div);
                    good = 0;
                end
                if (k == len * div - 1) begin
                    chk("done_at_end", int'(tx_done_flag), 1);
                    chk("early_done", xdone, 0);
                    chk("active_cycles", act, len * div);
                    in_frame = 1'b0;
                end else if (tx_done_flag) begin
                    xdone++;
                end
                k++;
            end
        end
    end

    task automatic push(input logic [7:0] b, input logic [1:0] par);
        send    = 1'b1;
        data_in = b;
        q.push_back('{b, par, baud_rate});
        @(posedge clock);
        #1;
        send = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(!tx_active_flag && fifo_empty && !in_frame) && n < 3000) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk("idle_timeout", int'(n < 3000), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, d0, lows;
        reset       = 1'b1;
        send        = 1'b0;
        data_in     = 8'h00;
        parity_type = 2'b00;
        baud_rate   = 2'b11;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_tx", int'(data_tx), 1);
        chk("rst_active", int'(tx_active_flag), 0);
        chk("rst_done", int'(tx_done_flag), 0);
        chk("rst_empty", int'(fifo_empty), 1);
        chk("rst_full", int'(fifo_full), 0);
        chk("rst_err", int'(fifo_err), 0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        parity_type = 2'b10;
        push(8'hA5, 2'b10);
        chk("c1_empty", int'(fifo_empty), 0);
        chk("c1_tx", int'(data_tx), 1);
        chk("c1_active", int'(tx_active_flag), 0);
        @(posedge clock);
        #1;
        chk("c2_tx", int'(data_tx), 0);
        chk("c2_active", int'(tx_active_flag), 1);
        repeat (109) @(posedge clock);
        #1;
        chk("c111_done", int'(tx_done_flag), 1);
        chk("c111_active", int'(tx_active_flag), 1);
        @(posedge clock);
        #1;
        chk("c112_active", int'(tx_active_flag), 0);
        chk("c112_done", int'(tx_done_flag), 0);
        wait_idle();

        parity_type = 2'b01;
        push(8'h00, 2'b01);
        wait_idle();
        parity_type = 2'b00;
        push(8'h00, 2'b00);
        wait_idle();
        parity_type = 2'b11;
        push(8'h00, 2'b11);
        wait_idle();

        parity_type = 2'b00;
        baud_rate   = 2'b00;
        push(8'hFF, 2'b00);
        wait_idle();
        baud_rate = 2'b11;

        t0 = cyc;
        d0 = dn_cnt;
        for (int i = 0; i < 10; i++) begin
            send    = 1'b1;
            data_in = 8'(i + 1);
            if (i < 9) q.push_back('{8'(i + 1), 2'b00, 2'b11});
            @(posedge clock);
            #1;
            if (i == 7) chk("ovf_full_c8", int'(fifo_full), 0);
            if (i == 8) begin
                chk("ovf_full_c9", int'(fifo_full), 1);
                chk("ovf_err_c9", int'(fifo_err), 0);
            end
        end
        send = 1'b0;
        chk("ovf_err_c10", int'(fifo_err), 1);
        @(posedge clock);
        #1;
        chk("ovf_err_c11", int'(fifo_err), 0);
        while (dn_cnt - d0 < 9 && cyc - t0 < 3000) begin
            @(posedge clock);
            #1;
        end
        chk("ovf_span", cyc - t0, 902);
        chk("ovf_dones", dn_cnt - d0, 9);
        chk("ovf_empty", int'(fifo_empty), 1);
        repeat (150) @(posedge clock);
        #1;
        chk("ovf_no_extra", dn_cnt - d0, 9);
        chk("ovf_queue", q.size(), 0);

        parity_type = 2'b10;
        push(8'h3C, 2'b10);
        push(8'h55, 2'b00);
        repeat (28) @(posedge clock);
        #1;
        parity_type = 2'b00;
        wait_idle();

        push(8'h11, 2'b00);
        push(8'h22, 2'b00);
        push(8'h33, 2'b00);
        d0 = dn_cnt;
        repeat (27) @(posedge clock);
        #1;
        reset = 1'b1;
        q.delete();
        @(posedge clock);
        #1;
        chk("rstm_tx", int'(data_tx), 1);
        chk("rstm_empty", int'(fifo_empty), 1);
        chk("rstm_active", int'(tx_active_flag), 0);
        reset = 1'b0;
        lows  = 0;
        repeat (300) begin
            @(posedge clock);
            #1;
            if (data_tx == 1'b0) lows++;
        end
        chk("rstm_quiet", lows, 0);
        chk("rstm_no_done", dn_cnt - d0, 0);
        chk("end_queue", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
